// File: rtl/sub_pkg.sv
// Shared types for the bit-serial subtractor: FSM state encoding and
// a helper that sizes the bit counter for a given operand width.
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    // Counter must be able to hold WIDTH itself, hence WIDTH+1.
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle of serial_subtractor. The ovf signal exists only
// when SUB_OVERFLOW_EN is defined.
interface serial_subtractor_if #(
    parameter int WIDTH = 4
);
    // Handshake: start is sampled only while idle (busy=0); a, b and bin are
    // captured on that edge. busy stays high until the cycle after the
    // one-cycle done pulse, and d/bout/ovf are valid from done onward.
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             bout;
`ifdef SUB_OVERFLOW_EN
    logic             ovf;
`endif

    modport master (
        output start, a, b, bin,
        input  busy, done, d, bout
`ifdef SUB_OVERFLOW_EN
        , input ovf
`endif
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, d, bout
`ifdef SUB_OVERFLOW_EN
        , output ovf
`endif
    );

endinterface

// File: rtl/my_full_subtractor.sv
// One-bit full subtractor: D = A - B - BIN with borrow-out, purely combinational.
module my_full_subtractor (
    input  logic A,
    input  logic B,
    input  logic BIN,
    output logic D,
    output logic BOUT
);

    assign D    = A ^ B ^ BIN;
    assign BOUT = (~A & B) | (BIN & ~(A ^ B));

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial ripple-borrow subtractor, LSB first, one full-subtractor cell.
// Define SUB_OVERFLOW_EN to add the registered signed-overflow output ovf.
module serial_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_subtractor_if.slave   bus,
    output state_t               dbg_state
);

    localparam int CNT_W = cnt_w(WIDTH);

    state_t             state;
    logic [WIDTH-1:0]   ra;
    logic [WIDTH-1:0]   rb;
    logic [WIDTH-1:0]   sr;
    logic               br;
    logic [CNT_W-1:0]   cnt;
    logic               di;
    logic               br_next;

    my_full_subtractor u_fs (
        .A    (ra[0]),
        .B    (rb[0]),
        .BIN  (br),
        .D    (di),
        .BOUT (br_next)
    );

    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ra       <= '0;
            rb       <= '0;
            sr       <= '0;
            br       <= 1'b0;
            cnt      <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.d    <= '0;
            bus.bout <= 1'b0;
`ifdef SUB_OVERFLOW_EN
            bus.ovf  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        ra       <= bus.a;
                        rb       <= bus.b;
                        br       <= bus.bin;
                        sr       <= '0;
                        cnt      <= '0;
                        bus.busy <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    sr  <= {di, sr[WIDTH-1:1]};
                    ra  <= ra >> 1;
                    rb  <= rb >> 1;
                    br  <= br_next;
                    cnt <= cnt + CNT_W'(1);
                    // Results only move on the final bit so d/bout stay stable mid-operation.
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        bus.d    <= {di, sr[WIDTH-1:1]};
                        bus.bout <= br_next;
`ifdef SUB_OVERFLOW_EN
                        bus.ovf  <= br ^ br_next;
`endif
                        bus.done <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and exhaustive bench for serial_subtractor (WIDTH=4); ovf checks
// are included when SUB_OVERFLOW_EN is defined.
module tb_serial_subtractor;
    import sub_pkg::*;

    localparam int WIDTH = 4;

    logic   clk = 1'b0;
    logic   rst;
    state_t dbg_state;

    serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int               n_cmp = 0;
    int               n_err = 0;
    logic [WIDTH-1:0] prev_d = '0;
    logic [WIDTH-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One operation: start for one cycle, scramble inputs mid-SHIFT, bounded wait for done.
    task automatic do_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                         input logic binv, input logic [WIDTH-1:0] exp_d,
                         input logic exp_b, input string tag);
        int cyc;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = av;
        bus.b     = bv;
        bus.bin   = binv;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 1;
        check({tag, "_busy"}, 32'(bus.busy), 32'd1);
        while (!bus.done && cyc < 12) begin
            if (cyc == 2) begin
                bus.a   = WIDTH'($urandom_range(0, 15));
                bus.b   = WIDTH'($urandom_range(0, 15));
                bus.bin = 1'($urandom_range(0, 1));
            end
            check({tag, "_hold_d"}, 32'(bus.d), 32'(prev_d));
            @(negedge clk);
            cyc++;
        end
        check({tag, "_latency"}, 32'(cyc), 32'd5);
        check({tag, "_d"}, 32'(bus.d), 32'(exp_d));
        check({tag, "_bout"}, 32'(bus.bout), 32'(exp_b));
        prev_d = exp_d;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.bin   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_d", 32'(bus.d), 32'd0);
        check("rst_bout", 32'(bus.bout), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        rst = 1'b0;

        do_op(4'd9, 4'd3, 1'b0, 4'd6, 1'b0, "op_9_3");
        @(negedge clk);
        check("op_9_3_busy_after", 32'(bus.busy), 32'd0);
        check("op_9_3_done_after", 32'(bus.done), 32'd0);
        do_op(4'd3, 4'd9, 1'b0, 4'hA, 1'b1, "op_3_9");
        do_op(4'd0, 4'd0, 1'b1, 4'hF, 1'b1, "op_0_0_1");
        do_op(4'd5, 4'd5, 1'b0, 4'd0, 1'b0, "op_5_5");
        do_op(4'd9, 4'd3, 1'b0, 4'd6, 1'b0, "op_pre_rst");

        // Abort: rst sampled on the edge that would compute bit 2.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 4'd12;
        bus.b     = 4'd5;
        bus.bin   = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_d", 32'(bus.d), 32'd0);
        check("abort_bout", 32'(bus.bout), 32'd0);
        check("abort_state", 32'(dbg_state), 32'(IDLE));
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("abort_no_done", 32'(bus.done), 32'd0);
        end
        prev_d = '0;
        do_op(4'd7, 4'd2, 1'b0, 4'd5, 1'b0, "after_abort");

        // start held high: one done every WIDTH+2 cycles.
        for (int i = 0; i < 5; i++) exp_q.push_back(4'd0);
        begin
            int last_n;
            last_n = -1;
            @(negedge clk);
            bus.start = 1'b1;
            bus.a     = 4'd1;
            bus.b     = 4'd1;
            bus.bin   = 1'b0;
            for (int n = 1; n <= 30; n++) begin
                @(negedge clk);
                if (bus.done) begin
                    if (last_n < 0) check("held_first", 32'(n), 32'd5);
                    else check("held_interval", 32'(n - last_n), 32'd6);
                    last_n = n;
                    if (exp_q.size() == 0) check("held_extra_done", 32'd1, 32'd0);
                    else check("held_d", 32'(bus.d), 32'(exp_q.pop_front()));
                    check("held_bout", 32'(bus.bout), 32'd0);
                end
            end
            bus.start = 1'b0;
            check("held_count", 32'(exp_q.size()), 32'd0);
        end
        prev_d = '0;

`ifdef SUB_OVERFLOW_EN
        do_op(4'd8, 4'd1, 1'b0, 4'd7, 1'b0, "ovf_8_1");
        check("ovf_8_1_ovf", 32'(bus.ovf), 32'd1);
        do_op(4'd7, 4'd1, 1'b0, 4'd6, 1'b0, "ovf_7_1");
        check("ovf_7_1_ovf", 32'(bus.ovf), 32'd0);
`endif

        for (int x = 0; x < 512; x++) begin
            logic [WIDTH-1:0] av;
            logic [WIDTH-1:0] bv;
            logic             binv;
            logic [WIDTH:0]   diff;
            av   = x[3:0];
            bv   = x[7:4];
            binv = x[8];
            diff = {1'b0, av} - {1'b0, bv} - {{WIDTH{1'b0}}, binv};
            do_op(av, bv, binv, diff[WIDTH-1:0], diff[WIDTH], "exh");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
